// File: rtl/bus_copy_pkg.sv
// Shared types and constants for the bus copy master.
// Optional read timeout is enabled by defining BUS_COPY_TIMEOUT_EN.
package bus_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [3:0]  FULL_BE    = 4'hf;
    localparam logic [31:0] ADDR_MASK  = 32'hffff_fffc;

endpackage

// File: rtl/bus_copy_timer.sv
// Loadable down-counter used to bound the wait for a read response.
// Only instantiated when BUS_COPY_TIMEOUT_EN is defined.
module bus_copy_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the last enabled cycle so the FSM leaves on the count'th cycle.
    assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/bus_copy_master.sv
// Block copy initiator: one read, then its write, one transaction at a time.
// Define BUS_COPY_TIMEOUT_EN to abort a read that never gets a response.
module bus_copy_master
    import bus_copy_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_addr_bi,
    input  logic [31:0]      dst_addr_bi,
    input  logic [LEN_W-1:0] len_bi,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [31:0]      bus_addr_bo,
    output logic [3:0]       bus_be_bo,
    output logic [31:0]      bus_wdata_bo,
    input  logic             bus_ack_i,
    input  logic             bus_resp_i,
    input  logic [31:0]      bus_rdata_bi
);

    state_e             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [31:0]        data_q, data_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               tmr_expire;

`ifdef BUS_COPY_TIMEOUT_EN
    localparam int TMR_W =
        ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic tmr_load;

    // Reloaded on every RD_REQ->RD_WAIT handoff.
    assign tmr_load = (state_q == RD_REQ) && bus_ack_i;

    bus_copy_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(TIMEOUT)),
        .en_i       (state_q == RD_WAIT),
        .expire_o   (tmr_expire)
    );
`else
    assign tmr_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_bi & ADDR_MASK;
                    dst_d   = dst_addr_bi & ADDR_MASK;
                    cnt_d   = len_bi;
                    err_d   = 1'b0;
                    state_d = (len_bi == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus_ack_i) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus_resp_i) begin
                    data_d  = bus_rdata_bi;
                    state_d = WR_REQ;
                end else if (tmr_expire) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                if (bus_ack_i) begin
                    src_d   = src_q + WORD_BYTES;
                    dst_d   = dst_q + WORD_BYTES;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o       = (state_q != IDLE);
        done_o       = (state_q == DONE);
        err_o        = err_q;
        bus_req_o    = 1'b0;
        bus_we_o     = 1'b0;
        bus_addr_bo  = '0;
        bus_be_bo    = '0;
        bus_wdata_bo = '0;
        unique case (state_q)
            RD_REQ: begin
                bus_req_o   = 1'b1;
                bus_addr_bo = src_q;
                bus_be_bo   = FULL_BE;
            end
            WR_REQ: begin
                bus_req_o    = 1'b1;
                bus_we_o     = 1'b1;
                bus_addr_bo  = dst_q;
                bus_be_bo    = FULL_BE;
                bus_wdata_bo = data_q;
            end
            default: begin
                bus_req_o = 1'b0;
            end
        endcase
    end

endmodule
